// File: rtl/sb_pkg.sv
// Shared register-scoreboard types and constants.
package sb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NREG       = 32;
  localparam int CNT_W      = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]      sb_cnt_t;
endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter: increment at issue, decrement at writeback,
// synchronous clear on flush, sticky underflow on writeback to an idle register.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             underflow
);

  logic uf_set;

  // A decrement at zero never moves the counter, even when paired with an increment.
  always_comb begin
    cnt_nxt = cnt;
    uf_set  = 1'b0;
    if (clr) begin
      cnt_nxt = '0;
    end else if (dec && (cnt == '0)) begin
      uf_set = 1'b1;
    end else if (inc && !dec && (cnt != '1)) begin
      cnt_nxt = cnt + 1'b1;
    end else if (dec && !inc) begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      underflow <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (uf_set) underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writes to x1..x31 and gates issue on RAW/saturation.
// Optional SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback release the hazard it resolves.
module reg_scoreboard #(
  parameter int NREG    = 32,
  parameter int CNT_W   = 2,
  parameter int STALL_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_we,
  input  sb_pkg::reg_addr_t   issue_rd,
  input  sb_pkg::reg_addr_t   issue_rs1,
  input  sb_pkg::reg_addr_t   issue_rs2,
  input  logic                issue_rs1_used,
  input  logic                issue_rs2_used,
  output logic                issue_ready,
  output logic                stall,
  input  logic                wb_valid,
  input  sb_pkg::reg_addr_t   wb_rd,
  input  logic                flush,
  output logic [NREG-1:0]     busy_vec,
  output logic [STALL_W-1:0]  stall_cycles,
  output logic                wb_underflow
);
  import sb_pkg::*;

  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];
  logic [NREG-1:0]  uf_vec;
  logic [NREG-1:0]  busy_nxt;
  logic             rs1_busy, rs2_busy, sat, accept;
  logic             byp_rs1, byp_rs2, byp_rd;

  assign cnt[0]      = '0;
  assign cnt_nxt[0]  = '0;
  assign uf_vec[0]   = 1'b0;
  assign busy_nxt[0] = 1'b0;

`ifdef SCOREBOARD_WB_BYPASS_EN
  assign byp_rs1 = wb_valid && (wb_rd == issue_rs1) && (cnt[issue_rs1] == CNT_W'(1));
  assign byp_rs2 = wb_valid && (wb_rd == issue_rs2) && (cnt[issue_rs2] == CNT_W'(1));
  assign byp_rd  = wb_valid && (wb_rd == issue_rd);
`else
  assign byp_rs1 = 1'b0;
  assign byp_rs2 = 1'b0;
  assign byp_rd  = 1'b0;
`endif

  always_comb begin
    rs1_busy = issue_rs1_used && (issue_rs1 != '0) && (cnt[issue_rs1] != '0) && !byp_rs1;
    rs2_busy = issue_rs2_used && (issue_rs2 != '0) && (cnt[issue_rs2] != '0) && !byp_rs2;
    sat      = issue_we && (issue_rd != '0) && (cnt[issue_rd] == '1) && !byp_rd;
  end

  assign issue_ready  = !(rs1_busy || rs2_busy || sat || flush);
  assign stall        = issue_valid && !issue_ready;
  assign accept       = issue_valid && issue_ready;
  assign wb_underflow = |uf_vec;

  for (genvar i = 1; i < NREG; i++) begin : g_cnt
    logic inc, dec;
    assign inc = accept && issue_we && (issue_rd == REG_ADDR_W'(i));
    // Flush suppresses the writeback so it can neither decrement nor flag underflow.
    assign dec = wb_valid && !flush && (wb_rd == REG_ADDR_W'(i));

    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc),
      .dec       (dec),
      .clr       (flush),
      .cnt       (cnt[i]),
      .cnt_nxt   (cnt_nxt[i]),
      .underflow (uf_vec[i])
    );

    assign busy_nxt[i] = |cnt_nxt[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_vec     <= '0;
      stall_cycles <= '0;
    end else begin
      busy_vec <= busy_nxt;
      if (stall && !flush && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Producer-side companion to the pipeline hazard/forwarding logic.
- Tracks in-flight writes to architectural registers x1..x31. Writes are marked pending at issue from decode and cleared at writeback.
- Gates issue with a RAW/saturation stall, and exports a registered busy vector and stall statistics.
- Sits between decode (issue port) and the writeback stage (retire port).

Parameters:
- NREG, 32, number of architectural registers; x0 is never tracked.
- CNT_W, 2, width of each per-register pending counter; max in-flight writes per register = 2**CNT_W-1.
- STALL_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- issue_valid  in  1  decode presents an instruction
- issue_we  in  1  instruction writes rd
- issue_rd  in  5  destination register
- issue_rs1  in  5  source register 1
- issue_rs2  in  5  source register 2
- issue_rs1_used  in  1  rs1 is read by the instruction
- issue_rs2_used  in  1  rs2 is read by the instruction
- issue_ready  out  1  instruction may issue this cycle (combinational)
- stall  out  1  issue_valid & ~issue_ready
- wb_valid  in  1  writeback retires a register write
- wb_rd  in  5  retiring destination
- flush  in  1  pipeline flush; all pending state discarded
- busy_vec  out  NREG  registered; bit i = counter[i] != 0
- stall_cycles  out  STALL_W  saturating count of stall cycles
- wb_underflow  out  1  sticky error: writeback to a register with counter 0

Behaviour:
- Reset values:
  - counters = 0, busy_vec = 0, stall_cycles = 0, wb_underflow = 0.
  - issue_ready = 1 and stall = 0 while issue_valid = 0.
- RAW check:
  - src_busy = (rs1_used & rs1!=0 & cnt[rs1]!=0) | (rs2_used & rs2!=0 & cnt[rs2]!=0).
- Saturation:
  - sat = issue_we & rd!=0 & cnt[rd]==2**CNT_W-1.
- issue_ready = ~src_busy & ~sat & ~flush.
- Accept = issue_valid & issue_ready. On accept with issue_we & rd!=0, cnt[rd] increments next edge.
- Writeback:
  - wb_valid & wb_rd!=0 & cnt[wb_rd]!=0: cnt[wb_rd] decrements next edge.
  - If the counter is 0: no change, and wb_underflow sets (sticky until rst).
  - wb_rd==0 is ignored.
- Simultaneous accept-increment and writeback to the same rd: counter unchanged. Underflow is still flagged if the counter was 0.
- Flush:
  - All counters clear next edge. Same-cycle issue and writeback are ignored; no underflow is flagged.
  - issue_ready = 0 during flush.
  - stall_cycles does not count flush cycles.
- busy_vec is updated from next-state counters, so it reflects the counter value one edge later. Bit 0 is always 0.
- stall_cycles increments on every cycle with stall=1. It holds at 2**STALL_W-1.
- Latency: an issued write shows busy the cycle after accept. A dependent instruction in that next cycle stalls.
- Reset mid-operation: all state clears asynchronously. A writeback arriving after reset is an underflow.

Optional Feature:
- Macro: SCOREBOARD_WB_BYPASS_EN.
- Defined:
  - A same-cycle writeback to a source register with cnt==1 removes that source from src_busy.
  - A same-cycle writeback to rd with cnt at saturation removes sat.
  - The dependent instruction issues in the writeback cycle, saving 1 stall cycle.
- Undefined: src_busy and sat use the registered counter only.

Decomposition:
- Package sb_pkg:
  - constants REG_ADDR_W=5, NREG=32
  - typedef reg_addr_t
  - typedef sb_cnt_t (CNT_W-bit)
- Sub-module sb_counter: one per-register up/down saturating counter with inc, dec, clr, underflow flag, instantiated NREG-1 times via generate.
- Top handles the RAW/saturation logic, stall statistics and busy_vec.

Test Plan:
- Back-to-back RAW:
  - Stimulus: issue add x5; next cycle issue sub using rs1=x5.
  - Response: stall=1 and stall_cycles increments each cycle until wb_valid, wb_rd=5.
  - Release: issue_ready rises the cycle after writeback. With SCOREBOARD_WB_BYPASS_EN, it rises in the writeback cycle.
- x0 handling:
  - Stimulus: issue rd=0 repeatedly, and read rs1=0.
  - Response: never stalls, busy_vec[0]=0. A writeback to x0 does not set underflow.
- Saturation, CNT_W=2:
  - Stimulus: issue three writes to x7 with no writeback, then a fourth.
  - Response: the fourth stalls (sat). One wb_rd=7 releases it.
- Simultaneous issue + writeback to x9 with cnt=1:
  - Response: cnt stays 1 and busy_vec[9] stays 1.
- Underflow and flush:
  - Stimulus: wb_rd=12 with cnt=0.
  - Response: wb_underflow=1 and stays set.
  - Stimulus: flush with x3 and x4 busy.
  - Response: busy_vec=0 next cycle, issue_ready=0 during flush, stall_cycles unchanged.
- Async reset mid-stall:
  - Stimulus: assert rst between edges.
  - Response: busy_vec, stall_cycles and wb_underflow go to 0 immediately, and issue_ready returns to 1.
